// File: rtl/mult_pkg.sv
// Shared types for the pipelined M-extension multiplier. Widths are sized for the largest
// configuration (XLEN=64); narrower instances use the low bits and keep the rest at zero.
package mult_pkg;

  localparam int MAX_XLEN      = 64;
  localparam int MAX_TAG_WIDTH = 8;
  localparam int MAX_BM_WIDTH  = 8;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'd0,
    MULT_MULH   = 2'd1,
    MULT_MULHSU = 2'd2,
    MULT_MULHU  = 2'd3
  } MULT_FUNC;

  typedef struct packed {
    logic                      valid;
    logic [2*MAX_XLEN-1:0]     sum;
    logic [2*MAX_XLEN-1:0]     mplier;
    logic [2*MAX_XLEN-1:0]     mcand;
    logic [MAX_TAG_WIDTH-1:0]  tag;
    logic [MAX_BM_WIDTH-1:0]   bm;
    MULT_FUNC                  func;
  } MULT_STAGE_PACKET;

  localparam MULT_STAGE_PACKET NOP_MULT_STAGE_PACKET = '{
    valid: 1'b0, sum: '0, mplier: '0, mcand: '0, tag: '0, bm: '0, func: MULT_MUL
  };

  // Widen a w-bit operand to 2*w bits (sign or zero fill); bits above 2*w stay zero.
  function automatic logic [2*MAX_XLEN-1:0] ext_operand(input logic [MAX_XLEN-1:0] v,
                                                        input int unsigned w,
                                                        input logic sgn);
    logic [2*MAX_XLEN-1:0] r;
    logic [2*MAX_XLEN-1:0] hi_mask;
    r       = {{MAX_XLEN{1'b0}}, v};
    hi_mask = ({(2*MAX_XLEN){1'b1}} >> (2*MAX_XLEN - 2*w)) &
              ~({(2*MAX_XLEN){1'b1}} >> (2*MAX_XLEN - w));
    if (sgn && v[w-1]) r = r | hi_mask;
    return r;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline slot: register, partial-product step, squash/resolve, free/advance.
// Post-step values are combinational from the register; loads whenever downstream frees it.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int STAGES   = 4,
  parameter int BM_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [BM_WIDTH-1:0]  b_mm_resolve,
  input  logic                 b_mm_mispred,
  input  MULT_STAGE_PACKET     src_pkt,
  input  logic                 down_free,
  output MULT_STAGE_PACKET     post_pkt,
  output logic                 ev,
  output logic                 free
);

  localparam int PW    = 2*MAX_XLEN;
  localparam int SHIFT = 2*XLEN/STAGES;
  localparam logic [PW-1:0] DMASK = {PW{1'b1}} >> (PW - 2*XLEN);

  MULT_STAGE_PACKET pkt_q, pkt_d;
  logic [BM_WIDTH-1:0] bm_cur;
  logic                adv;

  always_comb begin
    bm_cur = pkt_q.bm[BM_WIDTH-1:0];
    ev     = pkt_q.valid & ~(b_mm_mispred & |(bm_cur & b_mm_resolve));
    adv    = ev & down_free;
    free   = ~ev | adv;

    post_pkt        = pkt_q;
    post_pkt.valid  = ev;
    post_pkt.bm[BM_WIDTH-1:0] = bm_cur & ~b_mm_resolve;
    post_pkt.sum    = (pkt_q.sum + PW'(pkt_q.mplier[SHIFT-1:0]) * pkt_q.mcand) & DMASK;
    post_pkt.mplier = pkt_q.mplier >> SHIFT;
    post_pkt.mcand  = (pkt_q.mcand << SHIFT) & DMASK;

    // A held op keeps its operands but must still see branch resolution.
    pkt_d = pkt_q;
    pkt_d.bm[BM_WIDTH-1:0] = bm_cur & ~b_mm_resolve;
    if (free) pkt_d = src_pkt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pkt_q <= NOP_MULT_STAGE_PACKET;
    else       pkt_q <= pkt_d;
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined RV32/RV64 MUL/MULH/MULHSU/MULHU unit; STAGES-1 cycles accept-to-output, 1 op/cycle.
// Per-stage valid/ready with bubble collapsing; in_ready drops only when every stage is held.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int STAGES    = 4,
  parameter int BM_WIDTH  = 4,
  parameter int TAG_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_rs1,
  input  logic [XLEN-1:0]       in_rs2,
  input  logic [1:0]            in_func,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [BM_WIDTH-1:0]   in_bm,
  input  logic [BM_WIDTH-1:0]   b_mm_resolve,
  input  logic                  b_mm_mispred,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [BM_WIDTH-1:0]   out_bm,
  output logic                  busy
);

  MULT_STAGE_PACKET in_pkt;
  MULT_STAGE_PACKET src  [STAGES];
  MULT_STAGE_PACKET post [STAGES];
  MULT_STAGE_PACKET last;
  logic [STAGES-1:0] ev;
  logic              unused_tail;

  always_comb begin
    in_pkt        = NOP_MULT_STAGE_PACKET;
    in_pkt.valid  = in_valid & ~(b_mm_mispred & |(in_bm & b_mm_resolve));
    in_pkt.mcand  = ext_operand(MAX_XLEN'(in_rs1), XLEN,
                                (in_func == MULT_MULH) || (in_func == MULT_MULHSU));
    in_pkt.mplier = ext_operand(MAX_XLEN'(in_rs2), XLEN, in_func == MULT_MULH);
    in_pkt.tag[TAG_WIDTH-1:0] = in_tag;
    in_pkt.bm[BM_WIDTH-1:0]   = in_bm & ~b_mm_resolve;
    in_pkt.func   = MULT_FUNC'(in_func);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic free_k;
    logic dn_k;

    if (k == 0) begin : g_head
      assign src[k] = in_pkt;
    end else begin : g_body
      assign src[k] = post[k-1];
    end

    if (k == STAGES-1) begin : g_tail
      assign dn_k = out_ready;
    end else begin : g_mid
      assign dn_k = g_stage[k+1].free_k;
    end

    mult_pipe_stage #(
      .XLEN     (XLEN),
      .STAGES   (STAGES),
      .BM_WIDTH (BM_WIDTH)
    ) u_stage (
      .clock        (clock),
      .reset        (reset),
      .b_mm_resolve (b_mm_resolve),
      .b_mm_mispred (b_mm_mispred),
      .src_pkt      (src[k]),
      .down_free    (dn_k),
      .post_pkt     (post[k]),
      .ev           (ev[k]),
      .free         (free_k)
    );
  end

  assign last        = post[STAGES-1];
  assign in_ready    = g_stage[0].free_k;
  assign out_valid   = ev[STAGES-1];
  assign out_result  = (last.func == MULT_MUL) ? last.sum[XLEN-1:0] : last.sum[2*XLEN-1:XLEN];
  assign out_tag     = last.tag[TAG_WIDTH-1:0];
  assign out_bm      = last.bm[BM_WIDTH-1:0];
  assign busy        = |ev;
  assign unused_tail = ^last;

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe at XLEN=32, STAGES=4: directed ops push expectations,
// an output monitor pops and compares on every accepted result.
module tb_mult_pipe;

  localparam int XLEN = 32;
  localparam int STG  = 4;
  localparam int BMW  = 4;
  localparam int TW   = 6;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] in_rs1, in_rs2;
  logic [1:0]      in_func;
  logic [TW-1:0]   in_tag;
  logic [BMW-1:0]  in_bm, b_mm_resolve;
  logic            b_mm_mispred;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] out_result;
  logic [TW-1:0]   out_tag;
  logic [BMW-1:0]  out_bm;
  logic            busy;

  mult_pipe #(.XLEN(XLEN), .STAGES(STG), .BM_WIDTH(BMW), .TAG_WIDTH(TW)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func(in_func), .in_tag(in_tag), .in_bm(in_bm),
    .b_mm_resolve(b_mm_resolve), .b_mm_mispred(b_mm_mispred),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_bm(out_bm), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TW-1:0]   tag;
    logic [BMW-1:0]  bm;
  } exp_t;

  typedef struct {
    logic [1:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] r;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vt [9];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got tag %0d result 0x%0h, expected nothing", out_tag, out_result);
      end else begin
        mon_e = sb.pop_front();
        check("out_tag", out_tag, mon_e.tag);
        check("out_result", out_result, mon_e.res);
        check("out_bm", out_bm, mon_e.bm);
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after the op was presented for one edge.
  task automatic issue(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TW-1:0] t, input logic [BMW-1:0] m,
                       input bit expect_out, input logic [XLEN-1:0] er, input logic [BMW-1:0] ebm);
    in_valid = 1'b1; in_func = f; in_rs1 = a; in_rs2 = b; in_tag = t; in_bm = m;
    if (expect_out) sb.push_back('{er, t, ebm});
    @(negedge clock);
    check("in_ready_at_issue", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_queue_empty", sb.size(), 0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_func = 0; in_tag = 0; in_bm = 0;
    b_mm_resolve = 0; b_mm_mispred = 0; out_ready = 1;
    vt = '{
      '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
      '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
      '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{2'd3, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001},
      '{2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780},
      '{2'd1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
      '{2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE}
    };

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_bm", out_bm, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 0;
    @(posedge clock); #1;

    // Single MUL latency
    issue(2'd0, 32'd3, 32'd5, 6'd7, 4'b0000, 1, 32'd15, 4'b0000);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("latency_edges", cyc, 3);
    drain();

    // Back-to-back arithmetic vectors
    for (int i = 0; i < 9; i++)
      issue(vt[i].f, vt[i].a, vt[i].b, TW'(30 + i), 4'b0000, 1, vt[i].r, 4'b0000);
    drain();

    // Fill the pipe, then stall the consumer for 3 cycles
    issue(2'd0, 32'd2, 32'd3, 6'd10, 4'b0000, 1, 32'd6,  4'b0000);
    issue(2'd0, 32'd4, 32'd5, 6'd11, 4'b0000, 1, 32'd20, 4'b0000);
    issue(2'd0, 32'd6, 32'd7, 6'd12, 4'b0000, 1, 32'd42, 4'b0000);
    issue(2'd0, 32'd8, 32'd9, 6'd13, 4'b0000, 1, 32'd72, 4'b0000);
    out_ready = 0;
    #1;
    check("stall_out_valid", out_valid, 1);
    check("stall_in_ready_low", in_ready, 0);
    repeat (3) @(posedge clock);
    #1;
    check("stall_hold_tag", out_tag, 10);
    check("stall_in_ready_still_low", in_ready, 0);
    out_ready = 1;
    drain();

    // Mispredict: older op (bm 0001) in S2, younger (bm 0010) in S1; incoming op also squashed
    issue(2'd0, 32'd6, 32'd7, 6'd21, 4'b0001, 1, 32'd42, 4'b0001);
    issue(2'd0, 32'd9, 32'd9, 6'd22, 4'b0010, 0, 32'd81, 4'b0000);
    @(posedge clock); #1;
    b_mm_resolve = 4'b0010; b_mm_mispred = 1;
    issue(2'd0, 32'd2, 32'd2, 6'd23, 4'b0010, 0, 32'd4, 4'b0000);
    b_mm_resolve = 4'b0000; b_mm_mispred = 0;
    check("mispred_next_in_ready", in_ready, 1);
    check("mispred_busy_survivor", busy, 1);
    drain();
    check("mispred_idle", busy, 0);

    // Resolve without mispredict: all three continue with the bit cleared
    issue(2'd0, 32'd6, 32'd7, 6'd24, 4'b0001, 1, 32'd42, 4'b0001);
    issue(2'd0, 32'd9, 32'd9, 6'd25, 4'b0010, 1, 32'd81, 4'b0000);
    @(posedge clock); #1;
    b_mm_resolve = 4'b0010; b_mm_mispred = 0;
    issue(2'd0, 32'd2, 32'd2, 6'd26, 4'b0010, 1, 32'd4, 4'b0000);
    b_mm_resolve = 4'b0000;
    drain();

    // Reset with three ops in flight
    issue(2'd0, 32'd11, 32'd11, 6'd40, 4'b0000, 0, 32'd0, 4'b0000);
    issue(2'd1, 32'd12, 32'd12, 6'd41, 4'b0000, 0, 32'd0, 4'b0000);
    issue(2'd3, 32'd13, 32'd13, 6'd42, 4'b0000, 0, 32'd0, 4'b0000);
    check("pre_reset_busy", busy, 1);
    reset = 1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_tag", out_tag, 0);
    @(posedge clock); #1;
    reset = 0;
    seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("post_reset_no_output", seen, 0);
    check("post_reset_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised, fully pipelined RV32/RV64 M-extension multiplier for the MULT functional unit, placed between issue and the complete/CDB stage.
- Supports MUL, MULH, MULHSU and MULHU with per-stage valid/ready back-pressure, bubble collapsing and branch-mask squash/resolve in every stage.
- Generalises the single partial-product stage into a complete unit with configurable width and depth and signed modes.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- STAGES, 4, pipeline depth; must divide 2*XLEN; SHIFT = 2*XLEN/STAGES bits retired per stage.
- BM_WIDTH, 4, branch-mask width.
- TAG_WIDTH, 6, destination physical-register tag width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  issue presents an op
- in_ready  out  1  pipe accepts the op this cycle
- in_rs1  in  XLEN  multiplicand source
- in_rs2  in  XLEN  multiplier source
- in_func  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- in_tag  in  TAG_WIDTH  destination tag
- in_bm  in  BM_WIDTH  branch mask of the op
- b_mm_resolve  in  BM_WIDTH  one-hot branch being resolved (0 = none)
- b_mm_mispred  in  1  the resolving branch mispredicted
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  XLEN  selected product half
- out_tag  out  TAG_WIDTH  destination tag
- out_bm  out  BM_WIDTH  current mask (resolve bit already cleared)
- busy  out  1  any stage holds a valid op

Behaviour:
- Reset (async, active-high): all stage valids = 0, out_valid = 0, out_result = 0, out_tag = 0, out_bm = 0, busy = 0. Reset mid-operation discards every in-flight op; no output is produced afterwards for it.
- Operand prep on accept:
  - mcand = rs1, sign-extended to 2*XLEN for MULH and MULHSU, zero-extended otherwise.
  - mplier = rs2, sign-extended for MULH, zero-extended otherwise.
  - sum = 0.
- Stage k, combinational step:
  - sum += mplier[SHIFT-1:0] * mcand, computed modulo 2^(2*XLEN).
  - mplier is shifted right by SHIFT (zero fill).
  - mcand is shifted left by SHIFT.
- Stage registers: S0..S(STAGES-1). out_* are driven directly from the last stage's post-step values.
  - Result = sum[XLEN-1:0] for MUL, sum[2*XLEN-1:XLEN] for the others.
- Effective valid: ev_k = valid_k AND NOT(b_mm_mispred AND |(bm_k & b_mm_resolve)).
- Mask forwarded: bm_k & ~b_mm_resolve. This applies in all stages and to the incoming op in the same cycle.
- Advance rules:
  - Last stage: adv = ev_last & out_ready.
  - free_k = ~ev_k | adv_k.
  - Stage k loads from stage k-1 when free_k. Bubbles collapse, so a stage advances whenever the next stage is free, even while downstream stalls.
  - in_ready = free_0.
  - A loaded slot whose source is not effectively valid becomes invalid.
- Latency: an op accepted at edge T appears on out_valid after STAGES-1 further edges when unstalled. Throughput is 1 op/cycle.
- out_valid = ev_last. A squash of the last stage drops out_valid in the same cycle; the consumer must not take it.
- Incoming op squashed by a simultaneous mispredict with a matching in_bm bit: it is accepted if in_ready is high, then discarded (never becomes valid).
- Simultaneous resolve without mispred: the bit is cleared everywhere; the op continues.
- out_ready high with out_valid low: no effect.
- Stalled stage: holds all fields except bm, which still receives resolve clearing each cycle.
- busy = OR of ev_k.

Decomposition:
- Shared package mult_pkg:
  - MULT_FUNC enum.
  - MULT_STAGE_PACKET struct {valid, sum[2*XLEN], mplier[2*XLEN], mcand[2*XLEN], tag, bm, func}.
  - NOP_MULT_STAGE_PACKET with valid = 0.
- Sub-module mult_pipe_stage: one register slot plus partial-product step, squash/resolve logic, and free/adv computation. It is instantiated STAGES times by a generate loop in mult_pipe.

Test Plan (XLEN=32, STAGES=4, out_ready=1 unless stated):
- MUL 3*5, tag 7 -> out_valid 3 edges after accept, out_result 15, out_tag 7.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> result 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU rs1 0xFFFFFFFF, rs2 2 -> 0xFFFFFFFF.
- Four back-to-back MULs, out_ready low for 3 cycles once the first reaches the output:
  - in_ready falls once all 4 stages are full.
  - Results then emerge in order, one per cycle, with no loss or duplication.
- Op with bm 0b0010 in S1, plus an op with bm 0b0001 in S2; assert b_mm_resolve 0b0010 with b_mm_mispred=1:
  - The first op is never output.
  - The second is output with out_bm 0b0001.
  - Next cycle in_ready = 1.
- Same setup with b_mm_mispred=0 -> both ops complete; the first shows out_bm 0b0000.
- Reset asserted mid-flight with 3 valid ops -> out_valid and busy are 0 immediately; no result appears over the next 8 cycles.
